spi_xfer_ctrl: RTL and testbench
================================

// Module: spi_xfer_ctrl
// PURPOSE
//  Transfer sequencer for the SPI master, directly upstream of the shift-register stage.
//  - Generates SCLK and CS_n.
//  - Drives the shift-register stage controls: EnPISO, LoadPISO, SCLKEdgeFlg, WordFlg, TristateMode.
//  - Host interface: Start/Busy/Done. One word of WordLen bits per Start.
//  - SPI mode: CPHA=0 only; CPOL selectable.
// PARAMETERS
//  WordLen   8  bits per transfer (>=2)
//  DivWidth  8  width of ClkDiv
// PORTS
//  clk          in   1         system clock, all logic on posedge
//  rst_n        in   1         asynchronous, active-low reset
//  Start        in   1         request transfer; sampled only in IDLE
//  TxRx         in   1         1=transmit (drive MOSI), 0=receive; latched at Start
//  ClkDiv       in   DivWidth  SCLK half-period = ClkDiv+1 clk cycles; latched at Start
//  CPOL         in   1         SCLK idle level; tracked in IDLE, frozen while Busy
//  Busy         out  1         1 from cycle after accepted Start through DONE cycle
//  Done         out  1         one-cycle pulse at end of transfer
//  SCLK         out  1         serial clock
//  CS_n         out  1         chip select, active low
//  EnPISO       out  1         shift-register enable
//  LoadPISO     out  1         one-cycle parallel load strobe
//  SCLKEdgeFlg  out  1         one-cycle pulse per bit: shift/sample now
//  WordFlg      out  1         all WordLen bits done; blocks further shifting
//  TristateMode out  1         latched TxRx while Busy, 0 in IDLE (MOSI released)
// BEHAVIOUR
//  Reset (async, immediate, any state): FSM=IDLE, counters=0, CPOL latch=0.
//  - Outputs: SCLK=0, CS_n=1, Busy=0, Done=0, all PISO controls=0.
//  - Reset mid-transfer aborts with no Done pulse.
//  All outputs registered. SCLK = phase ^ CPOL_latch; phase=0 outside ACTIVE.
//  FSM states and transitions:
//  - IDLE: CPOL_latch<=CPOL each cycle.
//    - Start=1 -> LOAD; latch TxRx and ClkDiv in the same cycle.
//  - LOAD (1 cycle): CS_n=0, EnPISO=1, LoadPISO=1, TristateMode=TxRx_latch.
//    - Always -> ACTIVE.
//  - ACTIVE: CS_n=0, EnPISO=1. Half-period counter counts 0..ClkDiv.
//    - At terminal count, toggle phase and reset counter.
//    - Leading toggle (phase 0->1): SCLK leaves its idle level.
//    - Trailing toggle (phase 1->0): SCLKEdgeFlg=1 that same cycle; bitcnt+1.
//    - After the WordLen-th trailing toggle -> HOLD.
//  - HOLD: WordFlg=1 from the cycle after the final SCLKEdgeFlg.
//    - The final flag itself has WordFlg=0.
//    - CS_n stays 0 for one half-period (ClkDiv+1 cycles), then -> DONE.
//  - DONE (1 cycle): CS_n=1, Done=1, Busy=1, WordFlg=1, EnPISO=0.
//    - Always -> IDLE; Busy, WordFlg and TristateMode drop on entry to IDLE.
//  Timing:
//  - Latency: Start cycle=0; LOAD at 1; ACTIVE spans cycles 2..(2*WordLen*(ClkDiv+1)+1).
//  - Done asserts at cycle (2*WordLen+1)*(ClkDiv+1)+2.
//  - SCLKEdgeFlg pulses exactly WordLen times, spaced 2*(ClkDiv+1) cycles apart.
//  Boundary conditions:
//  - Start while Busy: ignored, not queued.
//  - Start held high: a new transfer begins the cycle after DONE (back-to-back; CS_n high 1 cycle).
//  - ClkDiv=0: SCLK toggles every clk.
//  - ClkDiv=all-ones: counter must not overflow before terminal compare.
//  - CPOL, TxRx, ClkDiv changes while Busy: no effect until next Start.
// TESTING
//  1 Reset: hold rst_n=0, toggle Start -> Busy=0, CS_n=1, SCLK=0, all controls 0; async deassert clean.
//  2 WordLen=8, ClkDiv=1, CPOL=0, TxRx=1, Start @0:
//    -> LoadPISO=1 @1; 8 SCLKEdgeFlg @6,10,..,34; WordFlg @35; Done @36; SCLK period 4.
//  3 CPOL=1, ClkDiv=0, TxRx=0:
//    -> SCLK idles 1; 8 low pulses of 1 cycle; TristateMode=0 throughout.
//    -> LoadPISO still pulses; Done @19.
//  4 Start pulsed again at cycles 5 and 20 of transfer 2 -> ignored; exactly one Done.
//  5 Start held high for 3 transfers -> CS_n high exactly 1 cycle between words; 24 edge flags.
//  6 rst_n=0 at cycle 15 of transfer 2 -> outputs idle within same cycle; no Done;
//    next Start runs a full clean transfer.

Source files
------------

// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer (CPHA=0, selectable CPOL): generates SCLK/CS_n and
// the load/shift/word strobes for the downstream shift-register stage.
module spi_xfer_ctrl #(
    parameter int unsigned WordLen  = 8,
    parameter int unsigned DivWidth = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                tx_rx_i,
    input  logic [DivWidth-1:0] clk_div_i,
    input  logic                cpol_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                sclk_o,
    output logic                cs_n_o,
    output logic                en_piso_o,
    output logic                load_piso_o,
    output logic                sclk_edge_flg_o,
    output logic                word_flg_o,
    output logic                tristate_mode_o
);

    localparam int unsigned BitW = $clog2(WordLen);
    localparam logic [BitW-1:0] LastBit = BitW'(WordLen - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACTIVE,
        S_HOLD,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [DivWidth-1:0] cnt_q, cnt_d;
    logic [DivWidth-1:0] div_q, div_d;
    logic [BitW-1:0]     bit_q, bit_d;
    logic                phase_q, phase_d;
    logic                txrx_q, txrx_d;
    logic                cpol_q, cpol_d;
    logic                edge_d;
    logic                accept;

    logic busy_q, done_q, sclk_q, cs_n_q, en_q, load_q, edge_q, word_q, tri_q;
    logic busy_d, done_d, sclk_d, cs_n_d, en_d, load_d, word_d, tri_d;
    logic in_xfer;

    // Next-state: half-period counter, SCLK phase and bit count sequencing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        phase_d = phase_q;
        txrx_d  = txrx_q;
        cpol_d  = cpol_q;
        edge_d  = 1'b0;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cpol_d = cpol_i;
                accept = start_i;
            end
            S_LOAD: begin
                state_d = S_ACTIVE;
                cnt_d   = '0;
            end
            S_ACTIVE: begin
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                    if (phase_q) begin
                        edge_d = 1'b1;
                        bit_d  = bit_q + BitW'(1);
                        if (bit_q == LastBit) begin
                            state_d = S_HOLD;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + DivWidth'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == div_q) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + DivWidth'(1);
                end
            end
            S_DONE: begin
                // A Start present in the DONE cycle chains straight into the next word
                if (start_i) begin
                    accept = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            state_d = S_LOAD;
            txrx_d  = tx_rx_i;
            div_d   = clk_div_i;
            cpol_d  = cpol_i;
            cnt_d   = '0;
            phase_d = 1'b0;
            bit_d   = '0;
        end
    end

    // Output decode from next state so every output comes straight off a flop
    always_comb begin
        in_xfer = (state_d == S_LOAD) || (state_d == S_ACTIVE) || (state_d == S_HOLD);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        cs_n_d  = ~in_xfer;
        en_d    = in_xfer;
        load_d  = (state_d == S_LOAD);
        sclk_d  = ((state_d == S_ACTIVE) & phase_d) ^ cpol_d;
        word_d  = (state_d == S_DONE) || ((state_d == S_HOLD) && (state_q == S_HOLD));
        tri_d   = busy_d & txrx_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            phase_q <= 1'b0;
            txrx_q  <= 1'b0;
            cpol_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            en_q    <= 1'b0;
            load_q  <= 1'b0;
            edge_q  <= 1'b0;
            word_q  <= 1'b0;
            tri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            phase_q <= phase_d;
            txrx_q  <= txrx_d;
            cpol_q  <= cpol_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            en_q    <= en_d;
            load_q  <= load_d;
            edge_q  <= edge_d;
            word_q  <= word_d;
            tri_q   <= tri_d;
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign sclk_o          = sclk_q;
    assign cs_n_o          = cs_n_q;
    assign en_piso_o       = en_q;
    assign load_piso_o     = load_q;
    assign sclk_edge_flg_o = edge_q;
    assign word_flg_o      = word_q;
    assign tristate_mode_o = tri_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: per-cycle comparison against a timing-formula model of a
// transfer, plus literal event-cycle checks on directed scenarios.
module tb_spi_xfer_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          tx_rx_i = 1'b0;
    logic [DW-1:0] clk_div_i = '0;
    logic          cpol_i = 1'b0;
    logic busy_o, done_o, sclk_o, cs_n_o, en_piso_o, load_piso_o;
    logic sclk_edge_flg_o, word_flg_o, tristate_mode_o;

    spi_xfer_ctrl #(.WordLen(W), .DivWidth(DW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_i         (start_i),
        .tx_rx_i         (tx_rx_i),
        .clk_div_i       (clk_div_i),
        .cpol_i          (cpol_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .sclk_o          (sclk_o),
        .cs_n_o          (cs_n_o),
        .en_piso_o       (en_piso_o),
        .load_piso_o     (load_piso_o),
        .sclk_edge_flg_o (sclk_edge_flg_o),
        .word_flg_o      (word_flg_o),
        .tristate_mode_o (tristate_mode_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a transfer is described only by its cycle offset from the accepting cycle.
    int   m_off = -1;
    int   m_h = 1;
    logic m_cpol = 1'b0;
    logic m_tx = 1'b0;

    // Vector order: {busy, done, sclk, cs_n, en, load, edge, word, tristate}
    function automatic logic [8:0] model_out(input int off, input int h, input logic cp, input logic tx);
        int   a_end, hold_end, d_off, ph;
        logic in_x, sclk, edge_f, word_f;
        if (off < 0) return {1'b0, 1'b0, cp, 1'b1, 5'b0};
        a_end    = 2 * W * h + 1;
        hold_end = a_end + h;
        d_off    = hold_end + 1;
        in_x     = (off <= hold_end);
        ph       = (off >= 2 && off <= a_end) ? ((off - 2) / h) % 2 : 0;
        sclk     = (ph != 0) ^ cp;
        edge_f   = (off >= 2 + 2 * h) && (off <= 2 + 2 * W * h) && (((off - 2) % (2 * h)) == 0);
        word_f   = (off >= 2 * W * h + 3);
        return {1'b1, off == d_off, sclk, ~in_x, in_x, off == 1, edge_f, word_f, tx};
    endfunction

    // Event logs, relative to t0 (the cycle Start was first driven)
    int   t0 = 0;
    int   load_q[$], edge_q[$], done_q[$], wordr_q[$], rise_q[$];
    int   fall_n = 0, csb_n = 0;
    logic tri_seen = 1'b0;
    logic sclk_prev = 1'b0, word_prev = 1'b0;
    logic [8:0] exp_v, act_v;

    task automatic clear_logs();
        load_q.delete(); edge_q.delete(); done_q.delete(); wordr_q.delete(); rise_q.delete();
        fall_n = 0; csb_n = 0; tri_seen = 1'b0;
    endtask

    always @(negedge clk) begin
        int rel;
        if (!rst_n) begin
            m_off  = -1;
            m_cpol = 1'b0;
        end
        exp_v = model_out(m_off, m_h, m_cpol, m_tx);
        act_v = {busy_o, done_o, sclk_o, cs_n_o, en_piso_o, load_piso_o,
                 sclk_edge_flg_o, word_flg_o, tristate_mode_o};
        chk("outputs_vs_model", int'(act_v), int'(exp_v));

        rel = cyc - t0;
        if (load_piso_o)              load_q.push_back(rel);
        if (sclk_edge_flg_o)          edge_q.push_back(rel);
        if (done_o)                   done_q.push_back(rel);
        if (word_flg_o && !word_prev) wordr_q.push_back(rel);
        if (sclk_o && !sclk_prev)     rise_q.push_back(rel);
        if (!sclk_o && sclk_prev)     fall_n++;
        if (cs_n_o && busy_o)         csb_n++;
        if (tristate_mode_o)          tri_seen = 1'b1;
        sclk_prev = sclk_o;
        word_prev = word_flg_o;

        if (rst_n) begin
            if (m_off < 0 || m_off == (2 * W + 1) * m_h + 2) begin
                if (start_i) begin
                    m_off  = 1;
                    m_h    = int'(clk_div_i) + 1;
                    m_tx   = tx_rx_i;
                    m_cpol = cpol_i;
                end else begin
                    if (m_off < 0) m_cpol = cpol_i;
                    m_off = -1;
                end
            end else begin
                m_off++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go(input int div, input logic cp, input logic tx);
        clk_div_i = DW'(div);
        cpol_i    = cp;
        tx_rx_i   = tx;
        start_i   = 1'b1;
        t0        = cyc;
        tick(1);
        start_i   = 1'b0;
    endtask

    initial begin
        // Reset held while Start toggles
        tick(1);
        for (int i = 0; i < 4; i++) begin
            start_i = ~start_i;
            tick(1);
        end
        start_i = 1'b0;
        chk("reset_busy", int'(busy_o), 0);
        chk("reset_cs_n", int'(cs_n_o), 1);
        chk("reset_sclk", int'(sclk_o), 0);
        chk("reset_ctrl", int'({en_piso_o, load_piso_o, sclk_edge_flg_o, word_flg_o, tristate_mode_o}), 0);
        rst_n = 1'b1;
        tick(3);

        // Basic transmit, ClkDiv=1, CPOL=0
        clear_logs();
        go(1, 1'b0, 1'b1);
        tick(40);
        chk("t2_load_cnt", load_q.size(), 1);
        chk("t2_load_at", load_q[0], 1);
        chk("t2_edge_cnt", edge_q.size(), 8);
        for (int i = 0; i < 8; i++) chk("t2_edge_at", edge_q[i], 6 + 4 * i);
        chk("t2_word_at", wordr_q[0], 35);
        chk("t2_done_cnt", done_q.size(), 1);
        chk("t2_done_at", done_q[0], 36);
        chk("t2_rise0", rise_q[0], 4);
        chk("t2_rise1", rise_q[1], 8);

        // CPOL=1, ClkDiv=0, receive
        cpol_i = 1'b1;
        tick(2);
        chk("t3_idle_sclk", int'(sclk_o), 1);
        clear_logs();
        go(0, 1'b1, 1'b0);
        tick(25);
        chk("t3_load_at", load_q[0], 1);
        chk("t3_done_at", done_q[0], 19);
        chk("t3_low_pulses", fall_n, 8);
        chk("t3_tristate", int'(tri_seen), 0);
        chk("t3_edge_cnt", edge_q.size(), 8);

        // Start pulses and input changes while busy are ignored
        cpol_i = 1'b0;
        tick(2);
        clear_logs();
        go(1, 1'b0, 1'b1);
        tick(4);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        cpol_i = 1'b1; tx_rx_i = 1'b0; clk_div_i = DW'(3);
        tick(14);
        start_i = 1'b1;
        tick(1);
        start_i = 1'b0;
        tick(20);
        chk("t4_done_cnt", done_q.size(), 1);
        chk("t4_done_at", done_q[0], 36);
        chk("t4_edge_cnt", edge_q.size(), 8);

        // Start held high: three back-to-back words
        cpol_i = 1'b0;
        tick(2);
        clear_logs();
        clk_div_i = DW'(1); tx_rx_i = 1'b1;
        start_i = 1'b1;
        t0 = cyc;
        tick(80);
        start_i = 1'b0;
        tick(40);
        chk("t5_edge_cnt", edge_q.size(), 24);
        chk("t5_done_cnt", done_q.size(), 3);
        chk("t5_done1", done_q[1], 72);
        chk("t5_done2", done_q[2], 108);
        chk("t5_cs_high_gaps", csb_n, 3);

        // Reset mid-transfer, then a clean transfer
        clear_logs();
        go(1, 1'b0, 1'b1);
        tick(14);
        rst_n = 1'b0;
        #1;
        chk("t6_abort_busy", int'(busy_o), 0);
        chk("t6_abort_cs_n", int'(cs_n_o), 1);
        tick(2);
        rst_n = 1'b1;
        tick(40);
        chk("t6_no_done", done_q.size(), 0);
        clear_logs();
        go(1, 1'b0, 1'b1);
        tick(40);
        chk("t6_done_at", done_q[0], 36);
        chk("t6_edge_cnt", edge_q.size(), 8);

        // Maximum divider: counter must reach all-ones before wrapping
        clear_logs();
        go(255, 1'b0, 1'b0);
        tick(4360);
        chk("t7_edge0", edge_q[0], 514);
        chk("t7_edge_cnt", edge_q.size(), 8);
        chk("t7_done_at", done_q[0], 4354);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
